mii_rx_byte_asm: RTL and testbench

- Sits directly downstream of the MII PHY interface on the receive path, in the recovered receive clock domain.
- Consumes the registered MII nibble stream: rxd, rx_dv, rx_er.
- Strips preamble/SFD, assembles nibbles into bytes (low nibble first) and emits a framed byte stream with last/error flags and per-frame status strobes for the MAC receive logic.

---
 rtl/eth_mii_pkg.sv | 16 +
 rtl/mii_rx_byte_asm.sv | 157 +++++++++++++++
 tb/tb_mii_rx_byte_asm.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_mii_pkg.sv
// MII receive nibble constants and byte-assembler state encoding.
package eth_mii_pkg;

   localparam logic [3:0] PREAMBLE_NIB      = 4'h5;
   localparam logic [3:0] SFD_NIB           = 4'hD;
   localparam logic [3:0] FALSE_CARRIER_NIB = 4'hE;

   typedef enum logic [2:0] {
      IDLE,
      PREAMBLE,
      DATA_LO,
      DATA_HI,
      DROP
   } rx_state_t;

endpackage

// File: rtl/mii_rx_byte_asm.sv
// MII receive byte assembler: strips preamble/SFD and packs nibbles (low first) into framed bytes.
// Bytes leave one byte late through a one-deep hold register so m_last can be flagged; no backpressure.
module mii_rx_byte_asm
   import eth_mii_pkg::*;
#(
   parameter int MIN_PREAMBLE = 2,
   parameter int MAX_LEN      = 1522,
   parameter int LEN_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       mii_rxd,
   input  logic             mii_rx_dv,
   input  logic             mii_rx_er,
   output logic [7:0]       m_data,
   output logic             m_valid,
   output logic             m_last,
   output logic             m_error,
   output logic [LEN_W-1:0] frame_len,
   output logic             stat_sfd_err,
   output logic             stat_false_carrier,
   output logic             stat_oversize
);

   rx_state_t        state;
   logic [3:0]       pre_cnt;
   logic [3:0]       lo_nib;
   logic [7:0]       hold_dat;
   logic             hold_vld;
   logic             err_flag;
   logic             ovf_seen;
   logic [LEN_W-1:0] byte_cnt;

   logic byte_done;
   logic eof;
   logic eof_err;

   assign byte_done = mii_rx_dv && (state == DATA_HI);
   assign eof       = !mii_rx_dv && ((state == DATA_LO) || (state == DATA_HI));
   // Ending in DATA_HI means an orphan nibble was received: the frame is bad.
   assign eof_err   = err_flag || (state == DATA_HI);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state              <= IDLE;
         pre_cnt            <= 4'd0;
         lo_nib             <= 4'd0;
         hold_dat           <= 8'd0;
         hold_vld           <= 1'b0;
         err_flag           <= 1'b0;
         ovf_seen           <= 1'b0;
         byte_cnt           <= '0;
         m_data             <= 8'd0;
         m_valid            <= 1'b0;
         m_last             <= 1'b0;
         m_error            <= 1'b0;
         frame_len          <= '0;
         stat_sfd_err       <= 1'b0;
         stat_false_carrier <= 1'b0;
         stat_oversize      <= 1'b0;
      end else begin
         m_valid            <= 1'b0;
         m_last             <= 1'b0;
         m_error            <= 1'b0;
         stat_sfd_err       <= 1'b0;
         stat_oversize      <= 1'b0;
         stat_false_carrier <= !mii_rx_dv && mii_rx_er && (mii_rxd == FALSE_CARRIER_NIB);

         case (state)
            IDLE: begin
               if (mii_rx_dv) begin
                  if (mii_rxd == PREAMBLE_NIB) begin
                     state   <= PREAMBLE;
                     pre_cnt <= 4'd1;
                  end else begin
                     state        <= DROP;
                     stat_sfd_err <= 1'b1;
                  end
               end
            end
            PREAMBLE: begin
               if (!mii_rx_dv) begin
                  state        <= IDLE;
                  stat_sfd_err <= 1'b1;
               end else if (!mii_rx_er && (mii_rxd == PREAMBLE_NIB)) begin
                  if (pre_cnt != 4'hF) pre_cnt <= pre_cnt + 4'd1;
               end else if (!mii_rx_er && (mii_rxd == SFD_NIB) &&
                            (pre_cnt >= 4'(MIN_PREAMBLE))) begin
                  state    <= DATA_LO;
                  byte_cnt <= '0;
                  err_flag <= 1'b0;
                  ovf_seen <= 1'b0;
                  hold_vld <= 1'b0;
               end else begin
                  state        <= DROP;
                  stat_sfd_err <= 1'b1;
               end
            end
            DATA_LO: begin
               if (mii_rx_dv) begin
                  lo_nib <= mii_rxd;
                  state  <= DATA_HI;
                  if (mii_rx_er) err_flag <= 1'b1;
               end else begin
                  state <= IDLE;
               end
            end
            DATA_HI: begin
               if (mii_rx_dv) begin
                  state <= DATA_LO;
                  if (mii_rx_er) err_flag <= 1'b1;
               end else begin
                  state    <= IDLE;
                  err_flag <= 1'b1;
               end
            end
            DROP: begin
               if (!mii_rx_dv) state <= IDLE;
            end
            default: state <= IDLE;
         endcase

         if (byte_done) begin
            if (byte_cnt == LEN_W'(MAX_LEN)) begin
               // Past MAX_LEN: keep the last stored byte held so it still carries m_last.
               err_flag <= 1'b1;
               if (!ovf_seen) begin
                  stat_oversize <= 1'b1;
                  ovf_seen      <= 1'b1;
               end
            end else begin
               byte_cnt <= byte_cnt + LEN_W'(1);
               hold_dat <= {mii_rxd, lo_nib};
               hold_vld <= 1'b1;
               if (hold_vld) begin
                  m_valid <= 1'b1;
                  m_data  <= hold_dat;
               end
            end
         end

         if (eof) begin
            hold_vld <= 1'b0;
            if (hold_vld) begin
               m_valid   <= 1'b1;
               m_last    <= 1'b1;
               m_data    <= hold_dat;
               m_error   <= eof_err;
               frame_len <= byte_cnt;
            end else begin
               stat_sfd_err <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_mii_rx_byte_asm.sv
// Randomized frame-level checks of mii_rx_byte_asm against a frame-rule reference model.
module tb_mii_rx_byte_asm;
   import eth_mii_pkg::*;

   localparam int MIN_PRE = 2;
   localparam int MAXL    = 4;
   localparam int LW      = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic [3:0]    mii_rxd;
   logic          mii_rx_dv;
   logic          mii_rx_er;
   logic [7:0]    m_data;
   logic          m_valid;
   logic          m_last;
   logic          m_error;
   logic [LW-1:0] frame_len;
   logic          stat_sfd_err;
   logic          stat_false_carrier;
   logic          stat_oversize;

   mii_rx_byte_asm #(.MIN_PREAMBLE(MIN_PRE), .MAX_LEN(MAXL), .LEN_W(LW)) dut (
      .clk(clk), .rst(rst),
      .mii_rxd(mii_rxd), .mii_rx_dv(mii_rx_dv), .mii_rx_er(mii_rx_er),
      .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_error(m_error),
      .frame_len(frame_len), .stat_sfd_err(stat_sfd_err),
      .stat_false_carrier(stat_false_carrier), .stat_oversize(stat_oversize)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]    d;
      logic          last;
      logic          err;
      logic [LW-1:0] len;
      int            cyc;
   } beat_t;

   beat_t      obs[$];
   logic [7:0] tx_bytes[$];
   int n_sfd, n_ovs, n_fc, cyc;
   int vectors = 0;
   int miscompares = 0;

   // Output monitor, sampling 1 time unit after each rising edge.
   always @(posedge clk) begin
      beat_t b;
      #1;
      cyc++;
      if (m_valid) begin
         b.d = m_data; b.last = m_last; b.err = m_error; b.len = frame_len; b.cyc = cyc;
         obs.push_back(b);
      end
      if (stat_sfd_err) n_sfd++;
      if (stat_oversize) n_ovs++;
      if (stat_false_carrier) n_fc++;
   end

   task automatic drive(input bit dv, input bit er, input logic [3:0] d);
      mii_rx_dv = dv; mii_rx_er = er; mii_rxd = d;
      @(negedge clk);
   endtask

   task automatic clear_obs();
      obs.delete(); n_sfd = 0; n_ovs = 0; n_fc = 0;
   endtask

   task automatic run_frame(input int npre, input logic [3:0] sfd, input bit extra,
                            input int er_idx, input int gap, input string name);
      beat_t exp_q[$];
      beat_t b;
      int nb, nstore, k, exp_sfd, exp_ovs;
      bit good, exp_err;
      nb = tx_bytes.size();
      clear_obs();
      for (int i = 0; i < npre; i++) drive(1'b1, 1'b0, 4'h5);
      drive(1'b1, 1'b0, sfd);
      k = 0;
      for (int i = 0; i < nb; i++) begin
         drive(1'b1, k == er_idx, tx_bytes[i][3:0]); k++;
         drive(1'b1, k == er_idx, tx_bytes[i][7:4]); k++;
      end
      if (extra) drive(1'b1, k == er_idx, 4'h7);
      for (int i = 0; i < gap; i++) drive(1'b0, 1'b0, 4'h0);

      // Reference: frame accepted only with enough 0x5 nibbles then 0xD.
      good    = (npre >= MIN_PRE) && (sfd == 4'hD);
      nstore  = (nb > MAXL) ? MAXL : nb;
      exp_err = extra || (er_idx >= 0) || (nb > MAXL);
      exp_sfd = (!good || nb == 0) ? 1 : 0;
      exp_ovs = (good && nb > MAXL) ? 1 : 0;
      if (good) begin
         for (int i = 0; i < nstore; i++) begin
            b.d = tx_bytes[i]; b.last = (i == nstore - 1);
            b.err = exp_err; b.len = LW'(nstore); b.cyc = 0;
            exp_q.push_back(b);
         end
      end

      vectors++;
      if (obs.size() !== exp_q.size()) begin
         miscompares++;
         $display("FAIL %s beat_count: got %0d expected %0d", name, obs.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
         vectors++;
         if (obs[i].d !== exp_q[i].d || obs[i].last !== exp_q[i].last) begin
            miscompares++;
            $display("FAIL %s beat%0d: got data %h last %b expected data %h last %b",
                     name, i, obs[i].d, obs[i].last, exp_q[i].d, exp_q[i].last);
         end
         if (exp_q[i].last) begin
            vectors++;
            if (obs[i].err !== exp_q[i].err || obs[i].len !== exp_q[i].len) begin
               miscompares++;
               $display("FAIL %s last_status: got err %b len %0d expected err %b len %0d",
                        name, obs[i].err, obs[i].len, exp_q[i].err, exp_q[i].len);
            end
         end
      end
      if (exp_q.size() >= 3 && obs.size() >= 2) begin
         vectors++;
         if (obs[1].cyc - obs[0].cyc !== 2) begin
            miscompares++;
            $display("FAIL %s beat_spacing: got %0d expected 2", name, obs[1].cyc - obs[0].cyc);
         end
      end
      vectors++;
      if (n_sfd !== exp_sfd || n_ovs !== exp_ovs || n_fc !== 0) begin
         miscompares++;
         $display("FAIL %s stats: got sfd %0d ovs %0d fc %0d expected sfd %0d ovs %0d fc 0",
                  name, n_sfd, n_ovs, n_fc, exp_sfd, exp_ovs);
      end
   endtask

   task automatic set_bytes3();
      tx_bytes.delete();
      tx_bytes.push_back(8'h11); tx_bytes.push_back(8'h22); tx_bytes.push_back(8'h33);
   endtask

   task automatic test_reset();
      rst = 1'b1; mii_rx_dv = 1'b0; mii_rx_er = 1'b0; mii_rxd = 4'h0;
      repeat (3) @(negedge clk);
      vectors++;
      if ({m_data, m_valid, m_last, m_error, stat_sfd_err, stat_false_carrier, stat_oversize} !== 14'd0
          || frame_len !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: got data %h vld %b last %b len %0d expected all zero",
                  m_data, m_valid, m_last, frame_len);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_normal();
      set_bytes3(); run_frame(15, 4'hD, 1'b0, -1, 3, "normal");
   endtask

   task automatic test_odd_nibble();
      set_bytes3(); run_frame(15, 4'hD, 1'b1, -1, 3, "odd_nibble");
   endtask

   task automatic test_rx_er();
      set_bytes3(); run_frame(15, 4'hD, 1'b0, 1, 3, "rx_er");
   endtask

   task automatic test_bad_sfd();
      set_bytes3(); run_frame(3, 4'hA, 1'b0, -1, 2, "bad_sfd");
      set_bytes3(); run_frame(2, 4'hD, 1'b0, -1, 2, "after_bad_sfd");
      set_bytes3(); run_frame(1, 4'hD, 1'b0, -1, 2, "short_preamble");
   endtask

   task automatic test_back_to_back();
      tx_bytes.delete();
      for (int i = 0; i < 6; i++) tx_bytes.push_back(8'(8'hA0 + i));
      run_frame(7, 4'hD, 1'b0, -1, 1, "oversize");
      set_bytes3(); run_frame(7, 4'hD, 1'b0, -1, 1, "b2b_after_oversize");
   endtask

   task automatic test_reset_mid_frame();
      int nlast;
      clear_obs();
      for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 4'h5);
      drive(1'b1, 1'b0, 4'hD);
      drive(1'b1, 1'b0, 4'h4); drive(1'b1, 1'b0, 4'hC);
      drive(1'b1, 1'b0, 4'h9); drive(1'b1, 1'b0, 4'h6);
      rst = 1'b1; mii_rx_dv = 1'b0;
      #1;
      vectors++;
      if ({m_valid, m_last, m_error, m_data} !== 11'd0 || frame_len !== '0) begin
         miscompares++;
         $display("FAIL reset_mid_outputs: got vld %b last %b data %h len %0d expected zero",
                  m_valid, m_last, m_data, frame_len);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (3) drive(1'b0, 1'b0, 4'h0);
      nlast = 0;
      foreach (obs[i]) if (obs[i].last) nlast++;
      vectors++;
      if (nlast !== 0) begin
         miscompares++;
         $display("FAIL reset_mid_no_last: got %0d last beats expected 0", nlast);
      end
      vectors++;
      if (obs.size() !== 1 || (obs.size() > 0 && obs[0].d !== 8'hC4)) begin
         miscompares++;
         $display("FAIL reset_mid_first_byte: got %0d beats expected 1 beat of c4", obs.size());
      end
      set_bytes3(); run_frame(2, 4'hD, 1'b0, -1, 2, "after_reset_mid");
   endtask

   task automatic test_false_carrier();
      clear_obs();
      repeat (3) drive(1'b0, 1'b1, 4'hE);
      drive(1'b0, 1'b1, 4'hD);
      drive(1'b0, 1'b0, 4'hE);
      repeat (2) drive(1'b0, 1'b0, 4'h0);
      vectors++;
      if (n_fc !== 3 || obs.size() !== 0) begin
         miscompares++;
         $display("FAIL false_carrier: got %0d pulses %0d beats expected 3 pulses 0 beats",
                  n_fc, obs.size());
      end
   endtask

   task automatic test_random();
      int npre, nb, nnib, er_idx, gap;
      logic [3:0] sfd;
      bit extra;
      for (int f = 0; f < 40; f++) begin
         npre = $urandom_range(0, 16);
         sfd  = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 4) != 0 || sfd == 4'h5) sfd = 4'hD;
         nb    = $urandom_range(0, 7);
         extra = ($urandom_range(0, 3) == 0);
         nnib  = 2 * nb + (extra ? 1 : 0);
         er_idx = (nnib > 0 && $urandom_range(0, 4) == 0) ? $urandom_range(0, nnib - 1) : -1;
         gap   = $urandom_range(1, 3);
         tx_bytes.delete();
         for (int i = 0; i < nb; i++) tx_bytes.push_back(8'($urandom));
         run_frame(npre, sfd, extra, er_idx, gap, $sformatf("random%0d", f));
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_normal();
      test_odd_nibble();
      test_rx_er();
      test_bad_sfd();
      test_back_to_back();
      test_reset_mid_frame();
      test_false_carrier();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
